seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed 7-segment display scanner with double-buffered content.
// A slot counter divides clk into digit slots; each slot starts with a short
// all-anodes-off guard window to avoid ghosting. New content is captured into
// shadow registers on load and applied only at a frame boundary, so a frame
// never shows a mix of old and new digits.
//
// Ports
//   clk         single clock
//   rst         synchronous, active-high reset
//   load        one-cycle strobe capturing data/dp_mask/blank_mask/lz_en
//   data        4 bits per digit, digit 0 in bits [3:0]
//   dp_mask     1 = decimal point lit on that digit
//   blank_mask  1 = digit fully dark (decimal point included)
//   lz_en       1 = leading-zero suppression
//   segments    {dp,g,f,e,d,c,b,a}, active-low, registered
//   anodes      digit enables, active-low, registered
//   frame_tick  one-cycle pulse when the digit index wraps to 0
//   upd_done    one-cycle pulse when pending shadow content is applied
// ---------------------------------------------------------------------------
module seg_scan_driver #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD_CYC   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   data,
   input  logic [NUM_DIGITS-1:0]     dp_mask,
   input  logic [NUM_DIGITS-1:0]     blank_mask,
   input  logic                      lz_en,
   output logic [7:0]                segments,
   output logic [NUM_DIGITS-1:0]     anodes,
   output logic                      frame_tick,
   output logic                      upd_done
);

   localparam int unsigned DATA_W = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);

   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYC);

   // Scan position
   logic [CNT_W-1:0]      div_cnt;
   logic [IDX_W-1:0]      idx;

   // Shadow (written by load) and active (displayed) content
   logic                  pending;
   logic [DATA_W-1:0]     shd_data,  act_data;
   logic [NUM_DIGITS-1:0] shd_dp,    act_dp;
   logic [NUM_DIGITS-1:0] shd_blank, act_blank;
   logic                  shd_lz,    act_lz;

   // Decode of the current scan position
   logic                  slot_end;
   logic                  frame_end;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic                  upper_zero;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  cur_blank;
   logic [6:0]            glyph;
   logic [7:0]            seg_nxt;
   logic [NUM_DIGITS-1:0] an_nxt;

   assign slot_end  = (div_cnt == DIV_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);

   // Next segment/anode pattern from the active content and scan position
   always_comb begin
      lz_blank   = '0;
      upper_zero = 1'b1;
      cur_nib    = 4'h0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      glyph      = 7'h7F;
      seg_nxt    = 8'hFF;
      an_nxt     = '1;

      // A digit is suppressed when it and every digit above it are zero;
      // digit 0 always shows so a zero value still reads "0".
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         upper_zero = upper_zero & (act_data[4*k +: 4] == 4'h0);
         if (k > 0) begin
            lz_blank[k] = act_lz & upper_zero;
         end
      end

      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            cur_nib   = act_data[4*k +: 4];
            cur_dp    = act_dp[k];
            cur_blank = act_blank[k] | lz_blank[k];
         end
      end

      // {g,f,e,d,c,b,a}, active-low
      case (cur_nib)
         4'h0:    glyph = 7'h40;
         4'h1:    glyph = 7'h79;
         4'h2:    glyph = 7'h24;
         4'h3:    glyph = 7'h30;
         4'h4:    glyph = 7'h19;
         4'h5:    glyph = 7'h12;
         4'h6:    glyph = 7'h02;
         4'h7:    glyph = 7'h78;
         4'h8:    glyph = 7'h00;
         4'h9:    glyph = 7'h10;
         4'hA:    glyph = 7'h08;
         4'hB:    glyph = 7'h03;
         4'hC:    glyph = 7'h46;
         4'hD:    glyph = 7'h21;
         4'hE:    glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase

      seg_nxt = cur_blank ? 8'hFF : {~cur_dp, glyph};

      // Guard window at slot start keeps all digits off while segments settle
      if (div_cnt >= GUARD_END) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
               an_nxt[k] = 1'b0;
            end
         end
      end
   end

   // Scan counters, double buffer and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt    <= '0;
         idx        <= '0;
         pending    <= 1'b0;
         shd_data   <= '0;
         shd_dp     <= '0;
         shd_blank  <= '1;
         shd_lz     <= 1'b0;
         act_data   <= '0;
         act_dp     <= '0;
         act_blank  <= '1;
         act_lz     <= 1'b0;
         segments   <= 8'hFF;
         anodes     <= '1;
         frame_tick <= 1'b0;
         upd_done   <= 1'b0;
      end else begin
         div_cnt <= slot_end ? '0 : div_cnt + CNT_W'(1);
         if (slot_end) begin
            idx <= frame_end ? '0 : idx + IDX_W'(1);
         end

         frame_tick <= frame_end;
         upd_done   <= frame_end & pending;

         // Boundary applies the shadow as it stood before this cycle's load
         if (frame_end && pending) begin
            act_data  <= shd_data;
            act_dp    <= shd_dp;
            act_blank <= shd_blank;
            act_lz    <= shd_lz;
         end

         if (load) begin
            shd_data  <= data;
            shd_dp    <= dp_mask;
            shd_blank <= blank_mask;
            shd_lz    <= lz_en;
            pending   <= 1'b1;
         end else if (frame_end) begin
            pending   <= 1'b0;
         end

         segments <= seg_nxt;
         anodes   <= an_nxt;
      end
   end

endmodule
